pipelined_control_unit: RTL and testbench
=========================================

PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 The block SHALL have parameter ALUCTRL_W, default 3, ALUControl width; legal values 3 (base ALU set) or 4 (extended ALU set).
REQ-002 The block SHALL have parameter REG_W, default 5, register-index width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 Op  in  7  ID-stage opcode.
REQ-006 funct3  in  3  ID-stage funct3.
REQ-007 funct7  in  1  ID-stage instr bit 30.
REQ-008 rd_D, rs1_D, rs2_D  in  REG_W each  ID-stage register indices.
REQ-009 zero_E  in  1  ALU zero flag of the EX-stage instruction.
REQ-010 ALUSrc_E, Branch_E, jump_E  out  1 each  EX-stage controls.
REQ-011 ALUControl_E  out  ALUCTRL_W  EX-stage ALU operation.
REQ-012 PCSrc_E  out  1  redirect fetch (taken branch or jump).
REQ-013 Memwrite_M, MemRead_M  out  1 each  MEM-stage controls.
REQ-014 Regwrite_W, ResultSrc_W  out  1 each  WB-stage controls; rd_E, rd_M, rd_W  out  REG_W each.
REQ-015 stall_D  out  1  hold PC and IF/ID register; illegal_D  out  1  ID opcode unsupported.
REQ-016 illegal_cnt  out  16  saturating count of illegal instructions that entered EX.

Function
REQ-017 Decode SHALL be combinational in ID: load 0000011 -> ALUSrc,MemRead,Regwrite,ResultSrc, ALUOp=00; store 0100011 -> ALUSrc,Memwrite, ALUOp=00; R 0110011 -> Regwrite, ALUOp=10; I-ALU 0010011 -> ALUSrc,Regwrite, ALUOp=10; branch 1100011 -> Branch, ALUOp=01; jal 1101111 -> jump,Regwrite.
REQ-018 Any other Op SHALL decode all controls to 0 and assert illegal_D.
REQ-019 ALUOp 00 -> add; 01 -> sub; 10 -> by funct3: 000 add (sub only if Op[5]&funct7), 010 slt, 110 or, 111 and.
REQ-020 Encodings, ALUCTRL_W=3: add 000, sub 001, and 010, or 011, slt 101; any other funct3 -> add.
REQ-021 ALUCTRL_W=4 SHALL add: xor(100) 0100, sll(001) 0110, srl(101,funct7=0) 0111, sra(101,funct7=1) 1000; base ops zero-extended (add 0000, sub 0001, and 0010, or 0011, slt 0101).
REQ-022 Controls SHALL pass ID->EX->MEM->WB through pipeline registers: EX outputs valid 1 cycle after ID decode, MEM 2, WB 3; rd follows the same path.
REQ-023 PCSrc_E SHALL be combinational = jump_E | (Branch_E & zero_E).
REQ-024 Load-use hazard: stall_D = MemRead_E & (rd_E!=0) & (rd_E==rs1_D | rd_E==rs2_D), combinational.
REQ-025 When stall_D=1 the ID/EX register SHALL load a bubble (all controls 0, rd 0); EX/MEM and MEM/WB advance normally.
REQ-026 When PCSrc_E=1 the ID/EX register SHALL load a bubble; the EX instruction itself proceeds to MEM.
REQ-027 PCSrc_E=1 SHALL force stall_D=0 (flush priority over stall).
REQ-028 A bubble SHALL never assert Regwrite, Memwrite, MemRead, Branch or jump in any later stage.
REQ-029 illegal_cnt SHALL increment by 1 each cycle an illegal instruction is loaded into ID/EX (not on stall or flush bubbles) and saturate at 0xFFFF.

Reset
REQ-030 When rst=0 at a rising edge, all pipeline registers SHALL clear to 0 and illegal_cnt to 0; all registered outputs read 0 the following cycle.
REQ-031 Reset mid-stream SHALL discard all in-flight controls; no Regwrite_W/Memwrite_M pulse from pre-reset instructions after release.
REQ-032 Combinational outputs (stall_D, illegal_D, PCSrc_E) SHALL be 0 during reset with Op=0.

Verification
REQ-033 R-type sub (Op=0110011, funct3=000, funct7=1), ALUCTRL_W=3 -> cycle+1 ALUControl_E=001; cycle+3 Regwrite_W=1, ResultSrc_W=0.
REQ-034 lw rd=5 then add rs1=5 -> stall_D=1 for exactly 1 cycle; EX bubble (all 0); add reaches EX next cycle.
REQ-035 beq in EX with zero_E=1 while lw hazard in ID -> PCSrc_E=1, stall_D=0, ID/EX bubble next cycle.
REQ-036 ALUCTRL_W=4, Op=0110011, funct3=101, funct7=1 -> ALUControl_E=1000.
REQ-037 Op=1111111 for 3 cycles -> illegal_D=1, no control asserted in any stage, illegal_cnt=3; force count 0xFFFF, one more illegal -> stays 0xFFFF.
REQ-038 rst=0 with store in MEM and load in WB -> next cycle Memwrite_M=0, Regwrite_W=0, illegal_cnt=0.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: ID-stage decode, ID/EX -> EX/MEM -> MEM/WB control registers,
// load-use stall and branch/jump flush handling, plus a saturating illegal-instruction counter.
module pipelined_control_unit #(
   parameter int ALUCTRL_W = 3,
   parameter int REG_W     = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           Op,
   input  logic [2:0]           funct3,
   input  logic                 funct7,
   input  logic [REG_W-1:0]     rd_D,
   input  logic [REG_W-1:0]     rs1_D,
   input  logic [REG_W-1:0]     rs2_D,
   input  logic                 zero_E,
   output logic                 ALUSrc_E,
   output logic                 Branch_E,
   output logic                 jump_E,
   output logic [ALUCTRL_W-1:0] ALUControl_E,
   output logic                 PCSrc_E,
   output logic                 Memwrite_M,
   output logic                 MemRead_M,
   output logic                 Regwrite_W,
   output logic                 ResultSrc_W,
   output logic [REG_W-1:0]     rd_E,
   output logic [REG_W-1:0]     rd_M,
   output logic [REG_W-1:0]     rd_W,
   output logic                 stall_D,
   output logic                 illegal_D,
   output logic [15:0]          illegal_cnt
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam bit EXT = (ALUCTRL_W == 4);
   localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0000);
   localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0001);
   localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(4'b0010);
   localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(4'b0011);
   localparam logic [ALUCTRL_W-1:0] ALU_XOR = ALUCTRL_W'(4'b0100);
   localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4'b0101);
   localparam logic [ALUCTRL_W-1:0] ALU_SLL = ALUCTRL_W'(4'b0110);
   localparam logic [ALUCTRL_W-1:0] ALU_SRL = ALUCTRL_W'(4'b0111);
   localparam logic [ALUCTRL_W-1:0] ALU_SRA = ALUCTRL_W'(4'b1000);

   typedef struct packed {
      logic                 alusrc;
      logic                 branch;
      logic                 jump;
      logic                 memw;
      logic                 memr;
      logic                 regw;
      logic                 ressrc;
      logic [ALUCTRL_W-1:0] aluctl;
      logic [REG_W-1:0]     rd;
   } ex_t;

   typedef struct packed {
      logic             memw;
      logic             memr;
      logic             regw;
      logic             ressrc;
      logic [REG_W-1:0] rd;
   } mem_t;

   typedef struct packed {
      logic             regw;
      logic             ressrc;
      logic [REG_W-1:0] rd;
   } wb_t;

   // Shift/xor codes exist only in the extended set; the base set falls back to add.
   function automatic logic [ALUCTRL_W-1:0] alu_dec(input logic [1:0] alu_op, input logic [2:0] f3,
                                                   input logic f7, input logic op5);
      logic [ALUCTRL_W-1:0] code;
      case (alu_op)
         2'b00: code = ALU_ADD;
         2'b01: code = ALU_SUB;
         2'b10: begin
            case (f3)
               3'b000:  code = (op5 & f7) ? ALU_SUB : ALU_ADD;
               3'b010:  code = ALU_SLT;
               3'b110:  code = ALU_OR;
               3'b111:  code = ALU_AND;
               3'b100:  code = EXT ? ALU_XOR : ALU_ADD;
               3'b001:  code = EXT ? ALU_SLL : ALU_ADD;
               3'b101:  code = EXT ? (f7 ? ALU_SRA : ALU_SRL) : ALU_ADD;
               default: code = ALU_ADD;
            endcase
         end
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

   ex_t         dec_s, ex_d, ex_q;
   mem_t        mem_d, mem_q;
   wb_t         wb_d, wb_q;
   logic [1:0]  alu_op_s;
   logic        illegal_raw_s, pcsrc_s, stall_s, bubble_s;
   logic [15:0] cnt_d, cnt_q;

   // ID-stage decode of opcode into control bundle
   always_comb begin
      dec_s         = '0;
      alu_op_s      = 2'b00;
      illegal_raw_s = 1'b0;
      case (Op)
         OP_LOAD: begin
            dec_s.alusrc = 1'b1;
            dec_s.memr   = 1'b1;
            dec_s.regw   = 1'b1;
            dec_s.ressrc = 1'b1;
         end
         OP_STORE: begin
            dec_s.alusrc = 1'b1;
            dec_s.memw   = 1'b1;
         end
         OP_RTYPE: begin
            dec_s.regw = 1'b1;
            alu_op_s   = 2'b10;
         end
         OP_IALU: begin
            dec_s.alusrc = 1'b1;
            dec_s.regw   = 1'b1;
            alu_op_s     = 2'b10;
         end
         OP_BRANCH: begin
            dec_s.branch = 1'b1;
            alu_op_s     = 2'b01;
         end
         OP_JAL: begin
            dec_s.jump = 1'b1;
            dec_s.regw = 1'b1;
         end
         default: illegal_raw_s = 1'b1;
      endcase
      dec_s.aluctl = alu_dec(alu_op_s, funct3, funct7, Op[5]);
      dec_s.rd     = illegal_raw_s ? {REG_W{1'b0}} : rd_D;
   end

   // Hazard/flush resolution and next-state for every pipeline register
   always_comb begin
      pcsrc_s  = rst & (ex_q.jump | (ex_q.branch & zero_E));
      stall_s  = rst & ~pcsrc_s & ex_q.memr & (ex_q.rd != {REG_W{1'b0}}) &
                 ((ex_q.rd == rs1_D) | (ex_q.rd == rs2_D));
      bubble_s = stall_s | pcsrc_s;
      if (bubble_s) begin
         ex_d = '0;
      end else begin
         ex_d = dec_s;
      end
      mem_d = '{memw: ex_q.memw, memr: ex_q.memr, regw: ex_q.regw, ressrc: ex_q.ressrc, rd: ex_q.rd};
      wb_d  = '{regw: mem_q.regw, ressrc: mem_q.ressrc, rd: mem_q.rd};
      if (illegal_raw_s && !bubble_s && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Pipeline and counter registers with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= 16'h0000;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         cnt_q <= cnt_d;
      end
   end

   assign ALUSrc_E     = ex_q.alusrc;
   assign Branch_E     = ex_q.branch;
   assign jump_E       = ex_q.jump;
   assign ALUControl_E = ex_q.aluctl;
   assign rd_E         = ex_q.rd;
   assign PCSrc_E      = pcsrc_s;
   assign Memwrite_M   = mem_q.memw;
   assign MemRead_M    = mem_q.memr;
   assign rd_M         = mem_q.rd;
   assign Regwrite_W   = wb_q.regw;
   assign ResultSrc_W  = wb_q.ressrc;
   assign rd_W         = wb_q.rd;
   assign stall_D      = stall_s;
   assign illegal_D    = rst & illegal_raw_s;
   assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench: table of single-instruction vectors followed through every stage,
// then hand-written sequences for stall, flush, illegal saturation and mid-stream reset.
module tb_pipelined_control_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] Op;
   logic [2:0] funct3;
   logic       funct7;
   logic [4:0] rd_D, rs1_D, rs2_D;
   logic       zero_E;

   logic       alusrc3, branch3, jump3, pcsrc3, memw3, memr3, regw3, ressrc3, stall3, ill3;
   logic [2:0] aluctl3;
   logic [4:0] rde3, rdm3, rdw3;
   logic [15:0] cnt3;
   logic       alusrc4, branch4, jump4, pcsrc4, memw4, memr4, regw4, ressrc4, stall4, ill4;
   logic [3:0] aluctl4;
   logic [4:0] rde4, rdm4, rdw4;
   logic [15:0] cnt4;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_cnt;

   always #5 clk = ~clk;

   pipelined_control_unit #(.ALUCTRL_W(3), .REG_W(5)) u3 (
      .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
      .rd_D(rd_D), .rs1_D(rs1_D), .rs2_D(rs2_D), .zero_E(zero_E),
      .ALUSrc_E(alusrc3), .Branch_E(branch3), .jump_E(jump3), .ALUControl_E(aluctl3),
      .PCSrc_E(pcsrc3), .Memwrite_M(memw3), .MemRead_M(memr3), .Regwrite_W(regw3),
      .ResultSrc_W(ressrc3), .rd_E(rde3), .rd_M(rdm3), .rd_W(rdw3),
      .stall_D(stall3), .illegal_D(ill3), .illegal_cnt(cnt3));

   pipelined_control_unit #(.ALUCTRL_W(4), .REG_W(5)) u4 (
      .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
      .rd_D(rd_D), .rs1_D(rs1_D), .rs2_D(rs2_D), .zero_E(zero_E),
      .ALUSrc_E(alusrc4), .Branch_E(branch4), .jump_E(jump4), .ALUControl_E(aluctl4),
      .PCSrc_E(pcsrc4), .Memwrite_M(memw4), .MemRead_M(memr4), .Regwrite_W(regw4),
      .ResultSrc_W(ressrc4), .rd_E(rde4), .rd_M(rdm4), .rd_W(rdw4),
      .stall_D(stall4), .illegal_D(ill4), .illegal_cnt(cnt4));

   // ctl = {alusrc, branch, jump, memw, memr, regw, ressrc, illegal}
   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic [2:0] a3;
      logic [3:0] a4;
      logic [7:0] ctl;
   } vec_t;

   vec_t tbl[15];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
      Op = op; funct3 = f3; funct7 = f7; rd_D = rd; rs1_D = r1; rs2_D = r2;
   endtask

   task automatic nop();
      drive(7'b0010011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0]  = '{7'b0000011, 3'b010, 1'b0, 3'd0, 4'd0, 8'b1000_1110};
      tbl[1]  = '{7'b0100011, 3'b010, 1'b0, 3'd0, 4'd0, 8'b1001_0000};
      tbl[2]  = '{7'b0110011, 3'b000, 1'b0, 3'd0, 4'd0, 8'b0000_0100};
      tbl[3]  = '{7'b0110011, 3'b000, 1'b1, 3'd1, 4'd1, 8'b0000_0100};
      tbl[4]  = '{7'b0110011, 3'b010, 1'b0, 3'd5, 4'd5, 8'b0000_0100};
      tbl[5]  = '{7'b0110011, 3'b110, 1'b0, 3'd3, 4'd3, 8'b0000_0100};
      tbl[6]  = '{7'b0110011, 3'b111, 1'b0, 3'd2, 4'd2, 8'b0000_0100};
      tbl[7]  = '{7'b0110011, 3'b100, 1'b0, 3'd0, 4'd4, 8'b0000_0100};
      tbl[8]  = '{7'b0110011, 3'b001, 1'b0, 3'd0, 4'd6, 8'b0000_0100};
      tbl[9]  = '{7'b0110011, 3'b101, 1'b0, 3'd0, 4'd7, 8'b0000_0100};
      tbl[10] = '{7'b0110011, 3'b101, 1'b1, 3'd0, 4'd8, 8'b0000_0100};
      tbl[11] = '{7'b0010011, 3'b000, 1'b1, 3'd0, 4'd0, 8'b1000_0100};
      tbl[12] = '{7'b1100011, 3'b000, 1'b0, 3'd1, 4'd1, 8'b0100_0000};
      tbl[13] = '{7'b1101111, 3'b000, 1'b0, 3'd0, 4'd0, 8'b0010_0100};
      tbl[14] = '{7'b1111111, 3'b000, 1'b0, 3'd0, 4'd0, 8'b0000_0001};

      // Reset with Op=0: everything reads zero
      rst = 1'b0; zero_E = 1'b0;
      drive(7'b0000000, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
      tick(); tick();
      check("rst_ex", 16'({alusrc3, branch3, jump3, aluctl3, rde3}), 16'h0000);
      check("rst_mw", 16'({memw3, memr3, rdm3, regw3, ressrc3, rdw3}), 16'h0000);
      check("rst_comb", 16'({stall3, ill3, pcsrc3}), 16'h0000);
      check("rst_cnt", cnt3, 16'h0000);
      nop();
      tick();
      rst = 1'b1;
      exp_cnt = 0;
      tick();

      // Each vector followed through EX, MEM and WB
      for (int i = 0; i < 15; i++) begin
         logic [4:0] erd;
         erd = tbl[i].ctl[0] ? 5'd0 : 5'(i + 1);
         drive(tbl[i].op, tbl[i].f3, tbl[i].f7, 5'(i + 1), 5'd0, 5'd0);
         #1;
         check($sformatf("v%0d_ill", i), 16'(ill3), 16'(tbl[i].ctl[0]));
         if (tbl[i].ctl[0]) exp_cnt++;
         tick();
         nop();
         check($sformatf("v%0d_ex", i), 16'({alusrc3, branch3, jump3}), 16'(tbl[i].ctl[7:5]));
         check($sformatf("v%0d_alu3", i), 16'(aluctl3), 16'(tbl[i].a3));
         check($sformatf("v%0d_alu4", i), 16'(aluctl4), 16'(tbl[i].a4));
         check($sformatf("v%0d_rdE", i), 16'(rde3), 16'(erd));
         check($sformatf("v%0d_pcsrc", i), 16'(pcsrc3), 16'(tbl[i].ctl[5]));
         tick();
         check($sformatf("v%0d_mem", i), 16'({memw3, memr3}), 16'(tbl[i].ctl[4:3]));
         check($sformatf("v%0d_rdM", i), 16'(rdm3), 16'(erd));
         tick();
         check($sformatf("v%0d_wb", i), 16'({regw3, ressrc3}), 16'(tbl[i].ctl[2:1]));
         check($sformatf("v%0d_rdW", i), 16'(rdw3), 16'(erd));
         check($sformatf("v%0d_cnt", i), cnt3, 16'(exp_cnt));
      end

      // Load-use: lw x5 then add x6,x5 -> one stall cycle with EX bubble
      drive(7'b0000011, 3'b010, 1'b0, 5'd5, 5'd0, 5'd0);
      tick();
      drive(7'b0110011, 3'b000, 1'b0, 5'd6, 5'd5, 5'd0);
      #1;
      check("lu_stall1", 16'(stall3), 16'h0001);
      tick();
      check("lu_bubble", 16'({alusrc3, branch3, jump3, aluctl3, rde3}), 16'h0000);
      check("lu_stall0", 16'(stall3), 16'h0000);
      check("lu_lw_mem", 16'({memr3, rdm3}), 16'({1'b1, 5'd5}));
      tick();
      nop();
      check("lu_add_ex", 16'(rde3), 16'd6);
      check("lu_bubble_mem", 16'({memw3, memr3, rdm3}), 16'h0000);
      tick();
      check("lu_bubble_wb", 16'({regw3, rdw3}), 16'h0000);
      tick();

      // Taken branch in EX flushes ID and takes priority over stall
      drive(7'b1100011, 3'b000, 1'b0, 5'd9, 5'd1, 5'd2);
      tick();
      drive(7'b0000011, 3'b010, 1'b0, 5'd3, 5'd9, 5'd0);
      #1;
      check("br_nt_pcsrc", 16'(pcsrc3), 16'h0000);
      zero_E = 1'b1;
      #1;
      check("br_t_pcsrc", 16'(pcsrc3), 16'h0001);
      check("br_t_stall", 16'(stall3), 16'h0000);
      tick();
      zero_E = 1'b0;
      nop();
      check("br_flush_ex", 16'({alusrc3, branch3, jump3, rde3}), 16'h0000);
      check("br_beq_mem", 16'(rdm3), 16'd9);
      tick();
      check("br_flush_mem", 16'({memw3, memr3}), 16'h0000);
      tick(); tick();

      // Three illegal instructions back to back
      drive(7'b1111111, 3'b000, 1'b0, 5'd4, 5'd0, 5'd0);
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("ill_D%0d", k), 16'(ill3), 16'h0001);
         tick();
      end
      exp_cnt += 3;
      check("ill_stages", 16'({regw3, ressrc3, memw3, memr3, alusrc3, branch3, jump3}), 16'h0000);
      check("ill_cnt3", cnt3, 16'(exp_cnt));
      for (int k = exp_cnt; k < 65535; k++) tick();
      check("ill_sat", cnt3, 16'hFFFF);
      tick(); tick();
      check("ill_sat_hold", cnt4, 16'hFFFF);
      nop();
      tick(); tick(); tick();

      // Reset with store in MEM and load in WB
      drive(7'b0000011, 3'b010, 1'b0, 5'd4, 5'd0, 5'd0);
      tick();
      drive(7'b0100011, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2);
      tick();
      nop();
      tick();
      check("mr_pre", 16'({memw3, regw3, rdw3}), 16'({1'b1, 1'b1, 5'd4}));
      rst = 1'b0;
      tick();
      check("mr_memw", 16'(memw3), 16'h0000);
      check("mr_regw", 16'(regw3), 16'h0000);
      check("mr_cnt", cnt3, 16'h0000);
      rst = 1'b1;
      tick();
      check("mr_post_m", 16'({memw3, memr3, rdm3}), 16'h0000);
      tick();
      check("mr_post_w", 16'({memw3, rdw3}), 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
